// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request/response and memory-side bundle for dmem_arbiter.
//   slave  modport: arbiter view (takes requests and mem_rdata, drives
//                   ready/rvalid/rdata, the memory command and busy)
//   master modport: environment view (requesters plus the memory array)
// Signals:
//   pN_valid/pN_we/pN_addr/pN_wdata  request from port N (N = 0 LSU, 1 loader)
//   pN_ready                         grant this cycle
//   pN_rvalid/pN_rdata               read response, one cycle after grant
//   mem_we/mem_addr/mem_wdata        memory command (combinational)
//   mem_rdata                        registered memory read data
//   busy                             a read response is pending
interface dmem_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 7
);
    logic              p0_valid;
    logic              p0_ready;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_valid;
    logic              p1_ready;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  p0_valid, p0_we, p0_addr, p0_wdata,
        input  p1_valid, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_ready, p0_rvalid, p0_rdata,
        output p1_ready, p1_rvalid, p1_rdata,
        output mem_we, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output p0_valid, p0_we, p0_addr, p0_wdata,
        output p1_valid, p1_we, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_ready, p0_rvalid, p0_rdata,
        input  p1_ready, p1_rvalid, p1_rdata,
        input  mem_we, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter / access sequencer for the 128 x 32
// single-port data memory. Port 0 is the CPU load/store unit, port 1 the
// debug/DMA loader. At most one access is granted per cycle; the memory
// command is driven combinationally from the granted port and synchronous
// read data is routed back to the requester of the read one cycle later.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    dmem_arbiter_if.slave (requests, responses, memory command, busy)
//
// Build option:
//   DMEM_ARB_RR_EN  defined   -> round-robin on conflict (loser of the last
//                                grant wins; port 0 first after reset)
//                   undefined -> fixed priority, port 0 wins on conflict
module dmem_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

`ifdef DMEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic rd_pend_q,    rd_pend_d;
    logic rd_port_q,    rd_port_d;
    logic last_grant_q, last_grant_d;

    logic              gnt0;
    logic              gnt1;
    logic              gnt_any;
    logic              pick_p1;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic              rvalid0;
    logic              rvalid1;

    // last_grant is tracked in both builds; only round-robin consults it.
    assign pick_p1 = RR_EN ? ~last_grant_q : 1'b0;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (bus.p0_valid && bus.p1_valid) begin
            gnt1 = pick_p1;
            gnt0 = ~pick_p1;
        end else begin
            gnt0 = bus.p0_valid;
            gnt1 = bus.p1_valid;
        end
    end

    assign gnt_any = gnt0 | gnt1;

    always_comb begin
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        if (gnt0) begin
            mem_we_c    = bus.p0_we;
            mem_addr_c  = bus.p0_addr;
            mem_wdata_c = bus.p0_wdata;
        end else if (gnt1) begin
            mem_we_c    = bus.p1_we;
            mem_addr_c  = bus.p1_addr;
            mem_wdata_c = bus.p1_wdata;
        end
    end

    always_comb begin
        rd_pend_d    = gnt_any & ~mem_we_c;
        rd_port_d    = rd_port_q;
        last_grant_d = last_grant_q;
        if (gnt_any) begin
            last_grant_d = gnt1;
            if (!mem_we_c) begin
                rd_port_d = gnt1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q    <= 1'b0;
            rd_port_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            rd_pend_q    <= rd_pend_d;
            rd_port_q    <= rd_port_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rvalid0 = rd_pend_q & ~rd_port_q;
    assign rvalid1 = rd_pend_q &  rd_port_q;

    assign bus.p0_ready  = gnt0;
    assign bus.p1_ready  = gnt1;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.p0_rvalid = rvalid0;
    assign bus.p1_rvalid = rvalid1;
    assign bus.p0_rdata  = rvalid0 ? bus.mem_rdata : '0;
    assign bus.p1_rdata  = rvalid1 ? bus.mem_rdata : '0;
    assign bus.busy      = rd_pend_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter. Includes a
// behavioural 128 x 32 memory with registered read, and a transaction-level
// reference model (memory image, expected pending response, last winner).
module tb_dmem_arbiter;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 7;
    localparam int VW = 109;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // memory array seen by the DUT
    logic [31:0] tb_mem [128];
    always @(posedge clk) begin
        if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= tb_mem[bus.mem_addr];
    end

    // reference model state
    logic [31:0] m_mem [128];
    bit          m_rv;
    bit          m_rp;
    logic [31:0] m_rd;
    bit          m_last;

    int errors = 0;
    int checks = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic m_reset();
        m_rv = 0; m_rp = 0; m_rd = '0; m_last = 1;
    endtask

    // requester that the arbitration rules say wins this cycle, -1 if none
    function automatic int m_winner();
        if (bus.p0_valid && bus.p1_valid) begin
`ifdef DMEM_ARB_RR_EN
            return (m_last == 1) ? 0 : 1;
`else
            return 0;
`endif
        end
        if (bus.p0_valid) return 0;
        if (bus.p1_valid) return 1;
        return -1;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        int w = m_winner();
        logic r0 = (w == 0);
        logic r1 = (w == 1);
        logic we = 0;
        logic [6:0] a = '0;
        logic [31:0] d = '0;
        logic v0 = m_rv && !m_rp;
        logic v1 = m_rv && m_rp;
        if (w == 0) begin we = bus.p0_we; a = bus.p0_addr; d = bus.p0_wdata; end
        if (w == 1) begin we = bus.p1_we; a = bus.p1_addr; d = bus.p1_wdata; end
        return {r0, r1, we, a, d, v0, (v0 ? m_rd : 32'h0), v1, (v1 ? m_rd : 32'h0), logic'(m_rv)};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {bus.p0_ready, bus.p1_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                bus.p0_rvalid, bus.p0_rdata, bus.p1_rvalid, bus.p1_rdata, bus.busy};
    endfunction

    task automatic drive(input logic v0, input logic we0, input logic [6:0] a0, input logic [31:0] d0,
                         input logic v1, input logic we1, input logic [6:0] a1, input logic [31:0] d1);
        @(negedge clk);
        bus.p0_valid = v0; bus.p0_we = we0; bus.p0_addr = a0; bus.p0_wdata = d0;
        bus.p1_valid = v1; bus.p1_we = we1; bus.p1_addr = a1; bus.p1_wdata = d1;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    // advance one clock and apply the transaction to the model
    task automatic tick();
        int w = m_winner();
        logic we = 0;
        logic [6:0] a = '0;
        logic [31:0] d = '0;
        if (w == 0) begin we = bus.p0_we; a = bus.p0_addr; d = bus.p0_wdata; end
        if (w == 1) begin we = bus.p1_we; a = bus.p1_addr; d = bus.p1_wdata; end
        @(posedge clk);
        if (!rst_n) begin
            m_reset();
        end else begin
            m_rv = 0;
            if (w >= 0) begin
                m_last = (w == 1);
                if (we) m_mem[a] = d;
                else begin m_rv = 1; m_rp = (w == 1); m_rd = m_mem[a]; end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        bus.p0_valid = 0; bus.p1_valid = 0;
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        m_reset();
        idle();
        checks++;
        if (obs_vec() !== '0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=0", obs_vec());
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_model got=%h exp=%h", obs_vec(), exp_vec());
        end
        tick();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_idle();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            idle();
            checks++;
            if ({bus.mem_we, bus.mem_addr, bus.p0_ready, bus.p1_ready, bus.p0_rvalid, bus.p1_rvalid, bus.busy} !== '0) begin
                errors++;
                $display("FAIL idle cyc=%0d got we=%b addr=%h rdy=%b%b rv=%b%b busy=%b exp all 0", i,
                         bus.mem_we, bus.mem_addr, bus.p0_ready, bus.p1_ready, bus.p0_rvalid, bus.p1_rvalid, bus.busy);
            end
            tick();
        end
    endtask

    task automatic test_write_read();
        do_reset();
        drive(1, 1, 7'd5, 32'hDEADBEEF, 0, 0, '0, '0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL wr_cycle1 got=%h exp=%h", obs_vec(), exp_vec());
        end
        tick();
        drive(1, 0, 7'd5, '0, 0, 0, '0, '0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL rd_cycle2 got=%h exp=%h", obs_vec(), exp_vec());
        end
        tick();
        idle();
        checks++;
        if (!(bus.p0_rvalid === 1'b1 && bus.p0_rdata === 32'hDEADBEEF && bus.p1_rvalid === 1'b0)) begin
            errors++;
            $display("FAIL rd_resp got rv0=%b rdata0=%h rv1=%b exp 1 deadbeef 0",
                     bus.p0_rvalid, bus.p0_rdata, bus.p1_rvalid);
        end
        tick();
    endtask

    task automatic test_conflict();
        logic [1:0] exp_g;
        do_reset();
        tb_mem[1] = 32'h11; m_mem[1] = 32'h11;
        tb_mem[2] = 32'h22; m_mem[2] = 32'h22;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 7'd1, '0, 1, 0, 7'd2, '0);
`ifdef DMEM_ARB_RR_EN
            exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp_g = 2'b10;
`endif
            checks++;
            if ({bus.p0_ready, bus.p1_ready} !== exp_g) begin
                errors++; $display("FAIL conflict_grant cyc=%0d got=%b exp=%b", i, {bus.p0_ready, bus.p1_ready}, exp_g);
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL conflict_model cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            tick();
        end
        drive(0, 0, '0, '0, 1, 0, 7'd2, '0);
        checks++;
        if ({bus.p0_ready, bus.p1_ready} !== 2'b01) begin
            errors++; $display("FAIL conflict_p1_after got=%b exp=01", {bus.p0_ready, bus.p1_ready});
        end
        tick();
        idle();
        checks++;
        if (!(bus.p1_rvalid === 1'b1 && bus.p1_rdata === 32'h22 && bus.p0_rvalid === 1'b0)) begin
            errors++; $display("FAIL conflict_p1_resp got rv1=%b rdata1=%h exp 1 22", bus.p1_rvalid, bus.p1_rdata);
        end
        tick();
    endtask

    task automatic test_wr_order();
        logic [31:0] old;
        do_reset();
        old = $urandom;
        tb_mem[127] = old; m_mem[127] = old;
        drive(1, 0, 7'd127, '0, 1, 1, 7'd127, 32'hA5A5A5A5);
        checks++;
        if ({bus.p0_ready, bus.p1_ready} !== 2'b10) begin
            errors++; $display("FAIL order_first got=%b exp=10", {bus.p0_ready, bus.p1_ready});
        end
        tick();
        drive(0, 0, '0, '0, 1, 1, 7'd127, 32'hA5A5A5A5);
        checks++;
        if (!(bus.p1_ready === 1'b1 && bus.mem_we === 1'b1 && bus.p0_rvalid === 1'b1 && bus.p0_rdata === old)) begin
            errors++; $display("FAIL order_old got rdy1=%b we=%b rv0=%b rdata0=%h exp 1 1 1 %h",
                               bus.p1_ready, bus.mem_we, bus.p0_rvalid, bus.p0_rdata, old);
        end
        tick();
        drive(1, 0, 7'd127, '0, 0, 0, '0, '0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL order_reread got=%h exp=%h", obs_vec(), exp_vec());
        end
        tick();
        idle();
        checks++;
        if (!(bus.p0_rvalid === 1'b1 && bus.p0_rdata === 32'hA5A5A5A5)) begin
            errors++; $display("FAIL order_new got rv0=%b rdata0=%h exp 1 a5a5a5a5", bus.p0_rvalid, bus.p0_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        drive(1, 0, 7'($urandom_range(0, 127)), '0, 0, 0, '0, '0);
        checks++;
        if (bus.p0_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_grant got=%b exp=1", bus.p0_ready);
        end
        tick();
        rst_n = 0;
        m_reset();
        for (int i = 0; i < 2; i++) begin
            idle();
            checks++;
            if (!(bus.p0_rvalid === 1'b0 && bus.busy === 1'b0)) begin
                errors++; $display("FAIL midrst_drop cyc=%0d got rv0=%b busy=%b exp 0 0", i, bus.p0_rvalid, bus.busy);
            end
            tick();
        end
        @(negedge clk);
        rst_n = 1;
        idle();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL midrst_release got=%h exp=%h", obs_vec(), exp_vec());
        end
        tick();
        drive(1, 0, 7'd3, '0, 1, 0, 7'd4, '0);
        checks++;
        if ({bus.p0_ready, bus.p1_ready} !== 2'b10) begin
            errors++; $display("FAIL midrst_conflict got=%b exp=10", {bus.p0_ready, bus.p1_ready});
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_random();
        bit          pv  [2];
        logic        pwe [2];
        logic [6:0]  pa  [2];
        logic [31:0] pd  [2];
        int issued = 0;
        int accepted = 0;
        logic [1:0] rdy;
        do_reset();
        pv[0] = 0; pv[1] = 0;
        for (int c = 0; c < 420; c++) begin
            if (c < 400) begin
                for (int k = 0; k < 2; k++) begin
                    if (!pv[k] && $urandom_range(0, 9) < 6) begin
                        pv[k] = 1; pwe[k] = 1'($urandom_range(0, 1));
                        pa[k] = 7'($urandom_range(0, 7)); pd[k] = $urandom;
                        issued++;
                    end
                end
            end
            drive(pv[0], pv[0] ? pwe[0] : 1'b0, pv[0] ? pa[0] : 7'd0, pv[0] ? pd[0] : 32'd0,
                  pv[1], pv[1] ? pwe[1] : 1'b0, pv[1] ? pa[1] : 7'd0, pv[1] ? pd[1] : 32'd0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            rdy = {bus.p1_ready, bus.p0_ready};
            tick();
            for (int k = 0; k < 2; k++) begin
                if (pv[k] && rdy[k]) begin pv[k] = 0; accepted++; end
            end
        end
        checks++;
        if (accepted !== issued || pv[0] || pv[1]) begin
            errors++; $display("FAIL random_accounting got accepted=%0d exp issued=%0d", accepted, issued);
        end
    endtask

    initial begin
        bus.p0_valid = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_valid = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_wdata = '0;
        bus.mem_rdata = '0;
        for (int i = 0; i < 128; i++) begin
            tb_mem[i] = $urandom;
            m_mem[i] = tb_mem[i];
        end
        test_reset();
        test_idle();
        test_write_read();
        test_conflict();
        test_wr_order();
        test_reset_mid_read();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
